// File: rtl/test_unit_pkg.sv
// Shared defaults for the test_unit input conditioner.
package test_unit_pkg;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 8;
endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer; every stage clears to 0 on reset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[N-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[N-1];
endmodule

// File: rtl/test_unit.sv
// Input conditioner: synchronizes `a`, debounces it onto `b`, and reports
// accepted transitions as one-cycle strobes plus a wrapping count.
module test_unit
    import test_unit_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    output logic             b,
    output logic             b_rise,
    output logic             b_fall,
    output logic [CNT_W-1:0] edge_cnt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic             a_s;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             b_q, b_d;
    logic             b_rise_q, b_rise_d;
    logic             b_fall_q, b_fall_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a),
        .q     (a_s)
    );

    // dcnt counts consecutive cycles a_s disagrees with b; the cycle that
    // reaches DCNT_MAX commits the new level and fires the matching strobe.
    always_comb begin
        dcnt_d     = dcnt_q;
        b_d        = b_q;
        b_rise_d   = 1'b0;
        b_fall_d   = 1'b0;
        edge_cnt_d = edge_cnt_q;
        if (a_s == b_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_MAX) begin
            dcnt_d     = '0;
            b_d        = a_s;
            b_rise_d   = a_s;
            b_fall_d   = ~a_s;
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q     <= '0;
            b_q        <= 1'b0;
            b_rise_q   <= 1'b0;
            b_fall_q   <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            dcnt_q     <= dcnt_d;
            b_q        <= b_d;
            b_rise_q   <= b_rise_d;
            b_fall_q   <= b_fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign b        = b_q;
    assign b_rise   = b_rise_q;
    assign b_fall   = b_fall_q;
    assign edge_cnt = edge_cnt_q;
endmodule

// File: tb/tb_test_unit.sv
// Bench for test_unit: a default instance and a narrow one (SYNC=3,
// DEBOUNCE=1, CNT_W=2) driven by the same input, checked against a model.
module tb_test_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0;
    logic       b0, r0, f0;
    logic [7:0] c0;
    logic       b1, r1, f1;
    logic [1:0] c1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    test_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .a(a),
        .b(b0), .b_rise(r0), .b_fall(f0), .edge_cnt(c0)
    );

    test_unit #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a),
        .b(b1), .b_rise(r1), .b_fall(f1), .edge_cnt(c1)
    );

    // Reference model: a_s used at edge t is the raw `a` sampled S edges
    // earlier; b flips once the last D a_s values all differ from b.
    int m_s  [2] = '{2, 3};
    int m_d  [2] = '{4, 1};
    int m_cw [2] = '{8, 2};
    bit m_pipe [2][0:7];
    bit m_hist [2][0:7];
    bit m_b    [2];
    bit m_rise [2];
    bit m_fall [2];
    int m_cnt  [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                m_pipe[m][i] = 1'b0;
                m_hist[m][i] = 1'b0;
            end
            m_b[m] = 1'b0; m_rise[m] = 1'b0; m_fall[m] = 1'b0; m_cnt[m] = 0;
        end
    endfunction

    function automatic void model_step(int m, bit a_now);
        bit used;
        bit all_diff;
        used = m_pipe[m][m_s[m]-1];
        for (int i = 7; i > 0; i--) m_pipe[m][i] = m_pipe[m][i-1];
        m_pipe[m][0] = a_now;
        for (int i = 7; i > 0; i--) m_hist[m][i] = m_hist[m][i-1];
        m_hist[m][0] = used;
        all_diff = 1'b1;
        for (int i = 0; i < m_d[m]; i++) if (m_hist[m][i] == m_b[m]) all_diff = 1'b0;
        m_rise[m] = 1'b0;
        m_fall[m] = 1'b0;
        if (all_diff) begin
            m_b[m]    = ~m_b[m];
            m_rise[m] = m_b[m];
            m_fall[m] = ~m_b[m];
            m_cnt[m]  = (m_cnt[m] + 1) % (1 << m_cw[m]);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, a);
            model_step(1, a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d0_b",    {31'd0, b0}, {31'd0, m_b[0]});
        chk("d0_rise", {31'd0, r0}, {31'd0, m_rise[0]});
        chk("d0_fall", {31'd0, f0}, {31'd0, m_fall[0]});
        chk("d0_cnt",  {24'd0, c0}, 32'(m_cnt[0]));
        chk("d1_b",    {31'd0, b1}, {31'd0, m_b[1]});
        chk("d1_rise", {31'd0, r1}, {31'd0, m_rise[1]});
        chk("d1_fall", {31'd0, f1}, {31'd0, m_fall[1]});
        chk("d1_cnt",  {30'd0, c1}, 32'(m_cnt[1]));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    int nr, nf, lat, rise_at;
    int wrap_exp [6] = '{1, 2, 3, 0, 1, 2};

    initial begin
        model_reset();
        // Reset held with a=1: everything stays cleared.
        a = 1'b1;
        rst_n = 1'b0;
        repeat (4) step();
        chk("rst_b", {31'd0, b0}, 32'd0);
        chk("rst_cnt", {24'd0, c0}, 32'd0);
        chk("rst_pulses", {30'd0, r0, f0}, 32'd0);
        a = 1'b0;
        step();
        rst_n = 1'b1;

        // Slow toggle, 10 cycles per level.
        nr = 0; nf = 0;
        for (int lv = 0; lv < 4; lv++) begin
            a = lv[0];
            for (int k = 0; k < 10; k++) begin
                step();
                if (r0) nr++;
                if (f0) nf++;
            end
        end
        chk("slow_rises", 32'(nr), 32'd2);
        chk("slow_falls", 32'(nf), 32'd1);
        chk("slow_cnt", {24'd0, c0}, 32'd3);

        // Glitch: settle low, then 3 cycles high.
        a = 1'b0;
        repeat (12) step();
        chk("glitch_pre_cnt", {24'd0, c0}, 32'd4);
        nr = 0;
        a = 1'b1;
        repeat (3) begin step(); if (r0) nr++; end
        a = 1'b0;
        repeat (10) begin step(); if (r0) nr++; end
        chk("glitch_b", {31'd0, b0}, 32'd0);
        chk("glitch_rises", 32'(nr), 32'd0);
        chk("glitch_cnt", {24'd0, c0}, 32'd4);

        // Threshold: held high, b appears after edge 6, strobe one cycle.
        a = 1'b1;
        lat = 0; rise_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (b0 && lat == 0) lat = k;
            if (r0) begin
                if (rise_at == 0) rise_at = k; else rise_at = -1;
            end
        end
        chk("thr_latency", 32'(lat), 32'd6);
        chk("thr_rise_once", 32'(rise_at), 32'd6);

        // Counter wrap on the CNT_W=2 instance.
        rst_n = 1'b0;
        a = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            a = ~a;
            repeat (6) step();
            chk($sformatf("wrap_%0d", t), {30'd0, c1}, 32'(wrap_exp[t]));
        end

        // Reset mid-debounce with a held high.
        a = 1'b0;
        repeat (12) step();
        a = 1'b1;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_b", {31'd0, b0}, 32'd0);
        chk("mid_rst_cnt", {24'd0, c0}, 32'd0);
        chk("mid_rst_cnt1", {30'd0, c1}, 32'd0);
        repeat (3) step();
        #2 rst_n = 1'b1;
        lat = 0; rise_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (b0 && lat == 0) lat = k;
            if (r0 && rise_at == 0) rise_at = k;
        end
        chk("rel_latency", 32'(lat), 32'd6);
        chk("rel_rise_at", 32'(rise_at), 32'd6);
        chk("rel_cnt", {24'd0, c0}, 32'd1);

        // Random levels with random hold times.
        repeat (60) begin
            a = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 9)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
